mc51_mem_arb: RTL

MC51_MEM_ARB -- requirements
Module: mc51_mem_arb

---
 rtl/mc51_pkg.sv | 41 ++++
 rtl/mc51_wait_timer.sv | 41 ++++
 rtl/mc51_mem_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mc51_pkg.sv
`default_nettype none
// ============================================================================
// mc51_pkg : shared types, constants and CPU strobe decode for mc51_mem_arb
// Revision : 1.0
// ============================================================================
package mc51_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2,
        RSP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

    localparam int unsigned WAIT_MAX_DEFAULT  = 15;
    localparam logic [7:0]  ERR_RDATA_DEFAULT = 8'hFF;

    typedef struct packed {
        logic rd;
        logic we;
        logic prg;
        logic conflict;
    } cpu_cmd_t;

    // Write outranks program read, which outranks data read.
    function automatic cpu_cmd_t cpu_decode(input logic psen_n, input logic rd_n, input logic we_n);
        cpu_cmd_t cmd;
        cmd.we       = ~we_n;
        cmd.prg      = we_n & ~psen_n;
        cmd.rd       = we_n & (~psen_n | ~rd_n);
        cmd.conflict = (~psen_n & ~rd_n) | (~psen_n & ~we_n) | (~rd_n & ~we_n);
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc51_wait_timer.sv
`default_nettype none
// ============================================================================
// mc51_wait_timer : counts unacknowledged access cycles, flags the limit cycle
// Revision : 1.0
// ============================================================================
module mc51_wait_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Fires on the limit-th enabled cycle after a clear.
    assign expired = en & ~clr & (count_q == limit - WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc51_mem_arb.sv
`default_nettype none
// ============================================================================
// mc51_mem_arb : arbitrates CPU and debug accesses onto one memory port
// Revision : 1.0
// ============================================================================
module mc51_mem_arb
    import mc51_pkg::*;
#(
    parameter int unsigned WAIT_MAX  = WAIT_MAX_DEFAULT,
    parameter logic [7:0]  ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_cpu_psen_n,
    input  logic        i_cpu_rd_n,
    input  logic        i_cpu_we_n,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_data_rdy,
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic        i_dbg_prg,
    input  logic [15:0] i_dbg_addr,
    input  logic [7:0]  i_dbg_wdata,
    output logic        o_dbg_gnt,
    output logic [7:0]  o_dbg_rdata,
    output logic        o_dbg_done,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_rd,
    output logic        o_mem_we,
    output logic        o_mem_prg,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_bus_err
);

    localparam logic [7:0] c_wait_limit = 8'(WAIT_MAX);

    arb_state_t  state_q,      state_d;
    owner_t      last_owner_q, last_owner_d;
    logic [15:0] mem_addr_q,   mem_addr_d;
    logic [7:0]  mem_wdata_q,  mem_wdata_d;
    logic        mem_rd_q,     mem_rd_d;
    logic        mem_we_q,     mem_we_d;
    logic        mem_prg_q,    mem_prg_d;
    logic [7:0]  cpu_rdata_q,  cpu_rdata_d;
    logic [7:0]  dbg_rdata_q,  dbg_rdata_d;
    logic        cpu_rdy_q,    cpu_rdy_d;
    logic        dbg_done_q,   dbg_done_d;
    logic        dbg_gnt_q,    dbg_gnt_d;
    logic        bus_err_q,    bus_err_d;

    cpu_cmd_t    w_cpu_cmd;
    logic        w_cpu_req;
    logic        w_cpu_wins;
    logic [7:0]  w_rdata;
    logic        w_timer_clr;
    logic        w_timer_en;
    logic        w_timer_expired;

    assign w_cpu_cmd  = cpu_decode(i_cpu_psen_n, i_cpu_rd_n, i_cpu_we_n);
    assign w_cpu_req  = ~i_cpu_psen_n | ~i_cpu_rd_n | ~i_cpu_we_n;
    // On a tie the requester that was not served last takes the bus.
    assign w_cpu_wins = w_cpu_req & (~i_dbg_req | (last_owner_q == OWNER_DBG));

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_we_d     = mem_we_q;
        mem_prg_d    = mem_prg_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_gnt_d    = dbg_gnt_q;
        cpu_rdy_d    = 1'b0;
        dbg_done_d   = 1'b0;
        bus_err_d    = 1'b0;
        w_rdata      = ERR_RDATA;
        w_timer_clr  = 1'b0;
        w_timer_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_cpu_wins) begin
                    state_d      = CPU_ACC;
                    last_owner_d = OWNER_CPU;
                    mem_addr_d   = i_cpu_addr;
                    mem_wdata_d  = i_cpu_wdata;
                    mem_rd_d     = w_cpu_cmd.rd;
                    mem_we_d     = w_cpu_cmd.we;
                    mem_prg_d    = w_cpu_cmd.prg;
                    bus_err_d    = w_cpu_cmd.conflict;
                    w_timer_clr  = 1'b1;
                end else if (i_dbg_req) begin
                    state_d      = DBG_ACC;
                    last_owner_d = OWNER_DBG;
                    mem_addr_d   = i_dbg_addr;
                    mem_wdata_d  = i_dbg_wdata;
                    mem_rd_d     = ~i_dbg_we;
                    mem_we_d     = i_dbg_we;
                    mem_prg_d    = i_dbg_prg;
                    dbg_gnt_d    = 1'b1;
                    w_timer_clr  = 1'b1;
                end
            end
            CPU_ACC, DBG_ACC: begin
                w_timer_en = ~i_mem_ack;
                // An ack landing on the limit cycle still counts as success.
                if (i_mem_ack || w_timer_expired) begin
                    state_d   = RSP;
                    mem_rd_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = ~i_mem_ack;
                    w_rdata   = i_mem_ack ? i_mem_rdata : ERR_RDATA;
                    if (state_q == CPU_ACC) begin
                        cpu_rdy_d = 1'b1;
                        if (mem_rd_q) begin
                            cpu_rdata_d = w_rdata;
                        end
                    end else begin
                        dbg_done_d = 1'b1;
                        if (mem_rd_q) begin
                            dbg_rdata_d = w_rdata;
                        end
                    end
                end
            end
            RSP: begin
                state_d   = IDLE;
                dbg_gnt_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_DBG;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_prg_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            dbg_rdata_q  <= 8'h00;
            cpu_rdy_q    <= 1'b0;
            dbg_done_q   <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            mem_prg_q    <= mem_prg_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dbg_done_q   <= dbg_done_d;
            dbg_gnt_q    <= dbg_gnt_d;
            bus_err_q    <= bus_err_d;
        end
    end

    mc51_wait_timer #(
        .WIDTH (8)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .limit   (c_wait_limit),
        .expired (w_timer_expired)
    );

    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_mem_rd       = mem_rd_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_prg      = mem_prg_q;
    assign o_cpu_rdata    = cpu_rdata_q;
    assign o_dbg_rdata    = dbg_rdata_q;
    assign o_cpu_data_rdy = cpu_rdy_q;
    assign o_dbg_done     = dbg_done_q;
    assign o_dbg_gnt      = dbg_gnt_q;
    assign o_bus_err      = bus_err_q;

endmodule
`default_nettype wire
